spi_slave_m: RTL and testbench

Byte-oriented SPI slave: the receiving end of the link driven by `spi_master_m`, operating in the same `CLK` domain. It samples the master's SCK, CS and MOSI, shifts in a byte while shifting out a preloaded reply on MISO, and presents the received byte with a one-cycle strobe. It sits between an external or on-chip SPI master and local register/FIFO logic, and supports back-to-back bytes within one CS frame.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_slave_m_if.sv | 38 +++
 rtl/spi_sync_m.sv | 33 +++
 rtl/spi_slave_m.sv | 138 +++++++++++++
 tb/tb_spi_slave_m.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared SPI definitions for the on-chip SPI master and slave blocks.
//   SPI_WIDTH        default bits per transfer
//   SPI_SYNC_STAGES  default synchronizer depth for pins from the master
//   SPI_CPOL/CPHA    link mode (mode 0: SCK idles low, sample on rising edge)
//   spi_state_e      frame state encoding (IDLE / ACTIVE)
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WIDTH       = 8;
    localparam int SPI_SYNC_STAGES = 2;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_m_if.sv
// ---------------------------------------------------------------------------
// spi_slave_m_if
// Bundles the SPI pins and the local byte interface of the SPI slave.
//   sck, cs, mosi  pins driven by the SPI master (cs active low)
//   miso           pin driven back to the master, MSB first
//   dout           reply byte supplied by local logic
//   din            last complete byte received
//   done           one-clock strobe when din updates
//   busy           high while a frame is active
// The master modport is the view of everything outside the slave: the
// remote master on the pins plus the local logic that supplies dout.
// ---------------------------------------------------------------------------
interface spi_slave_m_if
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
);

    logic             sck;
    logic             cs;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] din;
    logic             done;
    logic             busy;

    modport slave (
        input  sck, cs, mosi, dout,
        output miso, din, done, busy
    );

    modport master (
        output sck, cs, mosi, dout,
        input  miso, din, done, busy
    );

endinterface

// File: rtl/spi_sync_m.sv
// ---------------------------------------------------------------------------
// spi_sync_m
// N-stage single-bit synchronizer into the clk domain.
//   clk  system clock
//   rst  asynchronous active-high reset, clears every stage to 0
//   d    asynchronous input bit
//   q    synchronized output (last stage)
// ---------------------------------------------------------------------------
module spi_sync_m #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: clearing the chain to 0 (not to the idle level of CS) means a CS
    // pin held low across reset produces no falling edge, so the slave stays
    // idle until the master starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_m.sv
// ---------------------------------------------------------------------------
// spi_slave_m
// Byte-oriented mode-0 SPI slave running in the system clock domain.
// Shifts a byte in on MOSI while shifting a preloaded reply out on MISO,
// and supports back-to-back bytes inside one CS frame.
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   bus.sck   SPI clock from master (idle low)
//   bus.cs    chip select from master, active low
//   bus.mosi  serial data from master
//   bus.miso  serial data to master, MSB first
//   bus.dout  reply byte, loaded at frame start and at each byte boundary
//   bus.din   last complete received byte
//   bus.done  one-clock pulse when din updates
//   bus.busy  high while a frame is active
// ---------------------------------------------------------------------------
module spi_slave_m
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_m_if.slave      bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sck_s, cs_s, mosi_s;
    logic sck_d, cs_d;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    spi_sync_m #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .rst(rst), .d(bus.sck),  .q(sck_s));
    spi_sync_m #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst(rst), .d(bus.cs),   .q(cs_s));
    spi_sync_m #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_s));

    // NOTE: every register here uses non-blocking assignment so the edge
    // detector and the FSM all see the pre-edge values in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign cs_rise  =  cs_s  & ~cs_d;
    assign cs_fall  = ~cs_s  &  cs_d;

    spi_state_e       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] tx_sr;
    // Only the low WIDTH-1 bits of the receive history are ever needed:
    // the newest bit completes the byte straight into din.
    logic [WIDTH-2:0] rx_sr;
    logic [WIDTH-1:0] rx_next;
    logic             reload;
    logic             miso_q;
    logic [WIDTH-1:0] din_q;
    logic             done_q;
    logic             busy_q;

    assign rx_next = {rx_sr, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            reload  <= 1'b0;
            miso_q  <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        busy_q  <= 1'b1;
                        tx_sr   <= bus.dout;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        miso_q  <= bus.dout[WIDTH-1];
                    end
                end
                ACTIVE: begin
                    // CS release takes priority over any SCK edge seen in the
                    // same cycle; a partial byte is simply dropped.
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        miso_q  <= 1'b0;
                    end else if (sck_rise) begin
                        rx_sr <= rx_next[WIDTH-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            din_q   <= rx_next;
                            done_q  <= 1'b1;
                            bit_cnt <= '0;
                            reload  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        // The falling edge after a byte boundary presents the
                        // MSB of the next reply, which local logic may have
                        // refreshed in response to done.
                        if (reload) begin
                            tx_sr  <= bus.dout;
                            miso_q <= bus.dout[WIDTH-1];
                            reload <= 1'b0;
                        end else begin
                            tx_sr  <= tx_sr << 1;
                            miso_q <= tx_sr[WIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso = miso_q;
    assign bus.din  = din_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_spi_slave_m.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_m
// Self-checking bench for spi_slave_m. The bench plays the SPI master and
// the local reply logic; expected bytes come from the transfer lists
// themselves (master receives reply[b] for byte b, din holds the last full
// byte sent).
// ---------------------------------------------------------------------------
module tb_spi_slave_m;

    import spi_pkg::*;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int HMIN = S + 2;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [W-1:0] exp_din;

    spi_slave_m_if #(.WIDTH(W)) bus ();

    spi_slave_m #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock nbits of tx out MSB first with half-period h; returns the bits
    // seen on MISO. When done shows up, the next reply is placed on dout.
    task automatic xfer_byte(input logic [W-1:0] tx, input logic [W-1:0] next_dout,
                             input int nbits, input int h,
                             output logic [W-1:0] rx, output bit got_done);
        rx       = '0;
        got_done = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[3'(7 - i)];
            wait_clk(h);
            rx      = {rx[W-2:0], bus.miso};
            bus.sck = 1'b1;
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                if (bus.done === 1'b1 && !got_done) begin
                    got_done = 1'b1;
                    bus.dout = next_dout;
                end
            end
            bus.sck = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] tx[$],
                             input logic [W-1:0] rep[$], input int h);
        logic [W-1:0] rx;
        bit           gd;
        int           d0;
        d0       = done_cnt;
        bus.dout = rep[0];
        bus.cs   = 1'b0;
        wait_clk(h);
        check({name, "_busy_on"}, bus.busy, 1);
        for (int b = 0; b < tx.size(); b++) begin
            xfer_byte(tx[b], (b + 1 < rep.size()) ? rep[b+1] : rep[b], W, h, rx, gd);
            check({name, "_master_rx"}, rx, rep[b]);
            check({name, "_done_seen"}, gd, 1);
            check({name, "_din"}, bus.din, tx[b]);
        end
        wait_clk(h);
        bus.cs = 1'b1;
        wait_clk(2 * h);
        check({name, "_busy_off"}, bus.busy, 0);
        check({name, "_done_count"}, done_cnt - d0, tx.size());
        exp_din = tx[tx.size()-1];
    endtask

    initial begin
        logic [W-1:0] tq[$];
        logic [W-1:0] rq[$];
        logic [W-1:0] rx;
        bit           gd;
        int           d0;
        int           n;
        int           h;

        rst      = 1'b1;
        bus.cs   = 1'b1;
        bus.sck  = 1'b0;
        bus.mosi = 1'b0;
        bus.dout = '0;
        exp_din  = '0;
        wait_clk(3);
        check("reset_miso", bus.miso, 0);
        check("reset_din",  bus.din,  0);
        check("reset_done", bus.done, 0);
        check("reset_busy", bus.busy, 0);
        rst = 1'b0;
        wait_clk(6);
        check("idle_busy", bus.busy, 0);

        // Single byte.
        tq = '{8'h5D};
        rq = '{8'hA5};
        run_frame("single", tq, rq, 6);

        // Back-to-back bytes in one frame with a reply change on done.
        tq = '{8'h12, 8'h34};
        rq = '{8'hC3, 8'h3C};
        run_frame("b2b", tq, rq, 6);

        // Aborted byte after a completed 0x5D.
        tq = '{8'h5D};
        rq = '{8'hA5};
        run_frame("pre_abort", tq, rq, 6);
        d0     = done_cnt;
        bus.cs = 1'b0;
        wait_clk(6);
        xfer_byte(8'hFF, 8'h00, 5, 6, rx, gd);
        wait_clk(6);
        bus.cs = 1'b1;
        wait_clk(12);
        check("abort_din",  bus.din, exp_din);
        check("abort_done", done_cnt - d0, 0);
        check("abort_busy", bus.busy, 0);
        tq = '{8'h81};
        rq = '{8'h7E};
        run_frame("post_abort", tq, rq, 6);

        // SCK noise while deselected.
        d0       = done_cnt;
        bus.mosi = 1'b1;
        repeat (20) begin
            bus.sck = 1'b1;
            wait_clk(HMIN);
            bus.sck = 1'b0;
            wait_clk(HMIN);
        end
        wait_clk(HMIN);
        check("noise_done", done_cnt - d0, 0);
        check("noise_din",  bus.din, exp_din);
        check("noise_miso", bus.miso, 0);
        check("noise_busy", bus.busy, 0);

        // Reset in the middle of a byte; CS still low at release.
        bus.dout = 8'h96;
        bus.cs   = 1'b0;
        wait_clk(6);
        xfer_byte(8'hF0, 8'h96, 3, 6, rx, gd);
        check("pre_reset_busy", bus.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_miso", bus.miso, 0);
        check("midreset_din",  bus.din,  0);
        check("midreset_done", bus.done, 0);
        check("midreset_busy", bus.busy, 0);
        exp_din = '0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        check("post_reset_idle", bus.busy, 0);
        bus.cs = 1'b1;
        wait_clk(12);
        tq = '{8'hE7};
        rq = '{8'h5A};
        run_frame("post_reset", tq, rq, 6);

        // Minimum SCK phase length.
        tq = '{8'hFF, 8'hAA};
        rq = '{W'($urandom), W'($urandom)};
        run_frame("min_sck", tq, rq, HMIN);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 3));
            h = int'($urandom_range(HMIN, HMIN + 4));
            tq.delete();
            rq.delete();
            for (int b = 0; b < n; b++) begin
                tq.push_back(W'($urandom));
                rq.push_back(W'($urandom));
            end
            run_frame("rand", tq, rq, h);
        end
        check("final_din", bus.din, exp_din);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
